reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_word.sv | 30 +++
 rtl/reg_file.sv | 69 ++++++
 tb/tb_reg_file.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_pkg : shared widths, typedefs and constants for reg_file    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file_word : one DATA_W register, async reset, load enable        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_file_word #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // An X enable evaluates false here, so an unknown address never loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_file : 2-read / 1-write register file, register 0 reads as zero  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_file #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  import reg_file_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0]  w_wen;
  logic [DATA_W-1:0] w_regs [NREGS];

  always_comb begin
    w_wen = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i != ZERO_REG) begin
        w_wen[i] = we3 && (wa3 == ADDR_W'(i));
      end
    end
  end

  assign w_regs[ZERO_REG] = '0;

  generate
    for (genvar g = 1; g < NREGS; g++) begin : g_words
      reg_file_word #(
        .DATA_W (DATA_W)
      ) u_word (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_wen[g]),
        .i_d  (wd3),
        .o_q  (w_regs[g])
      );
    end
  endgenerate

  assign rd1 = w_regs[ra1];
  assign rd2 = w_regs[ra2];

  a_wa3_known : assert property (
    @(posedge clk) disable iff (reset) we3 |-> !$isunknown(wa3)
  );

  a_zero_rd1 : assert property (
    @(posedge clk) (ra1 == ADDR_W'(ZERO_REG)) |-> (rd1 == '0)
  );

  a_zero_rd2 : assert property (
    @(posedge clk) (ra2 == ADDR_W'(ZERO_REG)) |-> (rd2 == '0)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reg_file : scoreboard bench for reg_file                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_pass;

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .ra1   (ra1),
    .ra2   (ra2),
    .wa3   (wa3),
    .wd3   (wd3),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected values enter the queue when addresses are driven and leave it at sampling.
  task automatic sb_push_reads(input logic [4:0] a1, input logic [4:0] a2);
    ra1 = a1;
    ra2 = a2;
    exp_q.push_back(model[a1]);
    exp_q.push_back(model[a2]);
  endtask

  task automatic sb_compare(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    check_eq({tag, ".rd1"}, rd1, e1);
    check_eq({tag, ".rd2"}, rd2, e2);
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    sb_push_reads(a1, a2);
    #1;
    sb_compare(tag);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    if (!reset && a != 5'd0) model[a] = d;
    #1;
    we3 = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    we3      = 1'b0;
    ra1      = '0;
    ra2      = '0;
    wa3      = '0;
    wd3      = '0;
    clear_model();

    repeat (2) @(posedge clk);
    read_check("in_reset", 5'd9, 5'd31);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_check("reset_sweep", 5'(i), 5'(31 - i));
    end

    write_reg(5'd2, 32'd12);
    read_check("basic", 5'd2, 5'd3);

    @(negedge clk);
    we3 = 1'b0;
    wa3 = 5'd3;
    wd3 = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    read_check("we_off", 5'd2, 5'd3);

    write_reg(5'd0, 32'hFFFFFFFF);
    read_check("zero_reg", 5'd0, 5'd0);

    // Same-address read and write: old value before the edge, new after.
    write_reg(5'd5, 32'd7);
    @(negedge clk);
    sb_push_reads(5'd5, 5'd5);
    we3 = 1'b1;
    wa3 = 5'd5;
    wd3 = 32'd9;
    #1;
    sb_compare("rw_before");
    @(posedge clk);
    model[5] = 32'd9;
    #1;
    we3 = 1'b0;
    sb_push_reads(5'd5, 5'd5);
    #1;
    sb_compare("rw_after");

    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      read_check("fill", 5'(i), 5'(31 - i));
    end

    // Reset pulsed between edges must clear outputs without a clock.
    @(negedge clk);
    ra1 = 5'd7;
    ra2 = 5'd31;
    #1;
    check_eq("pre_async.rd1", rd1, 32'd7);
    reset = 1'b1;
    clear_model();
    #1;
    sb_push_reads(5'd7, 5'd31);
    #1;
    sb_compare("async_clr");
    we3 = 1'b1;
    wa3 = 5'd4;
    wd3 = 32'h55;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    read_check("during_rst", 5'd4, 5'd1);
    @(negedge clk);
    reset = 1'b0;
    read_check("post_rst", 5'd4, 5'd30);
    write_reg(5'd4, 32'hA5);
    read_check("first_write", 5'd4, 5'd0);

    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
      n_checks++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
